// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: launch FSM encoding and queue defaults.
package uart_pkg;

    localparam int unsigned DATA_W               = 8;
    localparam int unsigned DEPTH_DEFAULT        = 8;
    localparam int unsigned BUSY_TIMEOUT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/byte_fifo_mem.sv
// Circular byte storage for tx_byte_queue: data array, wrapping read/write pointers and occupancy.
module byte_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entries are never cleared; only slots between the pointers are ever read.
    always_ff @(posedge Clk) begin
        if (!Reset && push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/tx_byte_queue.sv
// Byte queue in front of a serial transmitter: buffers writes and launches one byte per
// transmitter handshake, with a sticky overflow flag for dropped writes.
module tx_byte_queue
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH        = DEPTH_DEFAULT,
    parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [7:0]             WrData,
    input  logic                   WrEn,
    input  logic                   ClrErr,
    input  logic                   TxBusy,
    output logic [7:0]             TxData,
    output logic                   TxStart,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Empty,
    output logic                   Full,
    output logic                   Overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    tx_state_e         state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;
    logic [DATA_W-1:0] head;
    logic [CW-1:0]     count;

    byte_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .Clk     (Clk),
        .Reset   (Reset),
        .push    (push),
        .pop     (pop),
        .wr_data (WrData),
        .rd_data (head),
        .count   (count)
    );

    assign Empty = (count == '0);
    assign Full  = (count == CW'(DEPTH));

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overflow_d = overflow_q;
        pop        = 1'b0;
        push       = WrEn && !Full;

        // A dropped write wins over a simultaneous clear.
        if (WrEn && Full)  overflow_d = 1'b1;
        else if (ClrErr)   overflow_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!Empty && !TxBusy) begin
                    pop       = 1'b1;
                    tx_data_d = head;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tx_start_d = 1'b1;
                tmo_d      = '0;
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A transmitter that never raises busy still counts the byte as sent.
                if (TxBusy)                                state_d = ST_WAIT_DONE;
                else if (tmo_q == TW'(BUSY_TIMEOUT - 1))   state_d = ST_IDLE;
                else                                       tmo_d   = tmo_q + 1'b1;
            end
            ST_WAIT_DONE: begin
                if (!TxBusy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overflow_q <= overflow_d;
        end
    end

    assign TxData   = tx_data_q;
    assign TxStart  = tx_start_q;
    assign Overflow = overflow_q;
    assign Count    = count;

endmodule
